// File: rtl/pio_pkg.sv
// Shared definitions for the pio_multi_irq parallel I/O block: register map
// word addresses and the per-bit edge polarity encoding.
package pio_pkg;

    localparam logic [2:0] PIO_ADDR_DATA   = 3'd0;
    localparam logic [2:0] PIO_ADDR_OUT    = 3'd1;
    localparam logic [2:0] PIO_ADDR_MASK   = 3'd2;
    localparam logic [2:0] PIO_ADDR_EDGE   = 3'd3;
    localparam logic [2:0] PIO_ADDR_OUTSET = 3'd4;
    localparam logic [2:0] PIO_ADDR_OUTCLR = 3'd5;
    localparam logic [2:0] PIO_ADDR_POL    = 3'd6;

    // One POL bit per input selects which transition of filt is captured.
    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } pio_edge_e;

endpackage

// File: rtl/pio_debounce.sv
// Sample-and-compare debounce: a bit of filt only follows sync when it has
// held the same value on two consecutive ticks, DEB_CYCLES clocks apart.
module pio_debounce #(
    parameter int WIDTH      = 18,
    parameter int DEB_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] filt
);

    localparam int            CW       = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] samp;
    logic [WIDTH-1:0] differs;

    assign differs = sync ^ samp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            samp <= '0;
            filt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            samp <= sync;
            filt <= (filt & differs) | (sync & ~differs);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pio_multi_irq.sv
// Avalon-MM parallel I/O: synchronised (optionally debounced) input bank with
// per-bit edge capture and masked irq, plus an output bank with atomic set/clear.
// Debounce is built only when PIO_DEBOUNCE_EN is defined.
module pio_multi_irq
    import pio_pkg::*;
#(
    parameter int               WIDTH      = 18,
    parameter logic [WIDTH-1:0] RESET_OUT  = '0,
    parameter int               DEB_CYCLES = 50000
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             avs_readdatavalid,
    output logic             irq,
    input  logic [WIDTH-1:0] pio_in,
    output logic [WIDTH-1:0] pio_out
);

    logic [WIDTH-1:0] sync0, sync1, filt, filt_d;
    logic [WIDTH-1:0] mask_r, edge_r, pol_r;
    logic [WIDTH-1:0] wd, cap, clr, edge_nxt;
    logic [31:0]      rd_word;
    logic             unused_wdata;

    assign wd           = avs_writedata[WIDTH-1:0];
    assign unused_wdata = ^avs_writedata;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync0 <= '0;
            sync1 <= '0;
        end else begin
            sync0 <= pio_in;
            sync1 <= sync0;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    pio_debounce #(
        .WIDTH      (WIDTH),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk  (clk_clk),
        .rst  (reset_reset),
        .sync (sync1),
        .filt (filt)
    );
`else
    localparam int unused_deb_cycles = DEB_CYCLES;
    assign filt = sync1;
`endif

    always_comb begin
        cap = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pio_edge_e'(pol_r[i]) == EDGE_FALL)
                cap[i] = ~filt[i] & filt_d[i];
            else
                cap[i] = filt[i] & ~filt_d[i];
        end
    end

    // A capture in the same cycle as its write-1-to-clear keeps the bit set.
    assign clr      = (avs_write && avs_address == PIO_ADDR_EDGE) ? wd : '0;
    assign edge_nxt = (edge_r & ~clr) | cap;

    always_comb begin
        rd_word = '0;
        case (avs_address)
            PIO_ADDR_DATA: rd_word[WIDTH-1:0] = filt;
            PIO_ADDR_OUT:  rd_word[WIDTH-1:0] = pio_out;
            PIO_ADDR_MASK: rd_word[WIDTH-1:0] = mask_r;
            PIO_ADDR_EDGE: rd_word[WIDTH-1:0] = edge_r;
            PIO_ADDR_POL:  rd_word[WIDTH-1:0] = pol_r;
            default:       rd_word = '0;
        endcase
    end

    // Bus: no waitrequest. A read sampled at edge N returns data with
    // readdatavalid high for the cycle after N, reflecting state before any
    // write sampled at the same edge N; writes update state at edge N.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            filt_d            <= '0;
            pio_out           <= RESET_OUT;
            mask_r            <= '0;
            edge_r            <= '0;
            pol_r             <= '0;
            irq               <= 1'b0;
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            filt_d            <= filt;
            edge_r            <= edge_nxt;
            irq               <= |(edge_r & mask_r);
            avs_readdatavalid <= avs_read;
            if (avs_read)
                avs_readdata <= rd_word;
            if (avs_write) begin
                case (avs_address)
                    PIO_ADDR_OUT:    pio_out <= wd;
                    PIO_ADDR_MASK:   mask_r  <= wd;
                    PIO_ADDR_OUTSET: pio_out <= pio_out | wd;
                    PIO_ADDR_OUTCLR: pio_out <= pio_out & ~wd;
                    PIO_ADDR_POL:    pol_r   <= wd;
                    default:         ;
                endcase
            end
        end
    end

endmodule

// File: doc/pio_multi_irq.md
# pio_multi_irq

Parametrised Avalon-MM parallel I/O block replacing the fixed-width key/switch/LED PIO exports in the lab SoC. One instance serves a WIDTH-bit input bank (keys or switches) and a WIDTH-bit output bank (LEDs). It adds behaviour the plain PIO lacks: synchronisation, optional debounce, per-bit edge capture with selectable polarity, masked interrupt, and atomic set/clear of outputs. It sits on the Nios II data master bus beside the SDRAM controller.

## Interface
- WIDTH, 18: bits per input and output bank, 1..32
- RESET_OUT, 0: output register value after reset
- DEB_CYCLES, 50000: clock cycles between debounce samples, ≥2
- clk_clk  in  1  system clock, all logic on rising edge
- reset_reset  in  1  asynchronous, active-high reset
- avs_address  in  3  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data, bits above WIDTH ignored
- avs_readdata  out  32  read data, zero-extended above WIDTH
- avs_readdatavalid  out  1  readdata qualifier
- irq  out  1  level interrupt to CPU
- pio_in  in  WIDTH  raw asynchronous inputs
- pio_out  out  WIDTH  output register

## Operation
- Register map (word address):
  - 0 DATA: read = filtered input; write ignored
  - 1 OUT: read/write output register
  - 2 MASK: read/write interrupt mask
  - 3 EDGE: read capture bits; write-1-to-clear
  - 4 OUTSET: write, OUT |= data; reads 0
  - 5 OUTCLR: write, OUT &= ~data; reads 0
  - 6 POL: read/write; bit 0 = rising-edge capture, 1 = falling
  - 7 reserved: reads 0, writes ignored
- Input path: 2-flop synchroniser on pio_in, then filter (see Configuration), giving `filt`.
- Edge capture: `filt_d` = filt delayed one cycle. Bit i is set when (POL[i]=0 and filt rises) or (POL[i]=1 and filt falls). Set is sticky until cleared.
- Same-cycle capture and write-1-to-clear on the same bit: set wins, bit stays 1.
- Same-cycle OUTSET/OUTCLR cannot occur (single address); OUT write is a full replacement.
- irq = registered OR of (EDGE & MASK).
- Simultaneous read and write: both are honoured; the read returns the pre-write value.
- Reset values: pio_out = RESET_OUT; MASK, EDGE, POL = 0; avs_readdata = 0; avs_readdatavalid = 0; irq = 0; synchroniser, filter and tick counter = 0.
- Reset during operation clears everything immediately (asynchronously), including pending captures.

## Timing
- Read latency is fixed at 1: avs_readdatavalid is high exactly one cycle after the avs_read cycle, with avs_readdata valid in that cycle. No waitrequest; back-to-back reads are allowed every cycle.
- Writes take effect at the clock edge that samples avs_write; pio_out changes the following cycle.
- pio_in to filt: 2 cycles without debounce; with debounce, up to 2·DEB_CYCLES+2 cycles.
- filt edge to EDGE bit: 1 cycle. EDGE bit to irq: 1 cycle.
- A clear write removes irq one cycle after the write edge if no other masked bit is set.

## Configuration
- PIO_DEBOUNCE_EN defined: a tick counter counts 0..DEB_CYCLES-1 and wraps. On each wrap, `samp` ← sync, and filt[i] ← sync[i] only where sync[i] equals samp[i]. The input must therefore be stable across two consecutive ticks to be accepted.
- PIO_DEBOUNCE_EN undefined: filt = synchroniser output. The counter is not instantiated and DEB_CYCLES is unused.

## Structure
- Shared package pio_pkg: address constants (PIO_ADDR_DATA … PIO_ADDR_POL) and the sample/edge enum.
- One sub-module, pio_debounce (counter, samp, filt), instantiated per bank under PIO_DEBOUNCE_EN.

## Test plan
- Reset with RESET_OUT=18'h00F0F → pio_out=18'h00F0F; irq=0; reading addr 3 returns 0 with readdatavalid one cycle later.
- Write OUT=18'h3FFFF, then OUTCLR=18'h0000F, then OUTSET=18'h00001 → pio_out=18'h3FFF1; reading addr 1 returns 32'h0003FFF1.
- Debounce off, MASK=1, POL=0: pio_in[0] goes 0→1 → EDGE[0]=1 at 3 cycles and irq=1 at 4 cycles; writing 1 to addr 3 drops irq next cycle.
- POL[2]=1: pio_in[2] rises, no capture; pio_in[2] falls, EDGE=32'h4.
- A capture edge coincides with a clear write on the same bit → EDGE stays 1 and irq stays asserted.
- PIO_DEBOUNCE_EN, DEB_CYCLES=4: a 3-cycle glitch on pio_in[1] leaves filt unchanged. A level held for 10 cycles appears on DATA.
